// File: rtl/dmem_io.sv
// dmem_io: data memory and memory-mapped I/O responder for the LEGLite
// single-cycle core. Loads are combinational so the core finishes a load in
// one cycle. Every state change happens on the rising clock edge.
//
// Memory map:
//   Any address outside 0xFFF0-0xFFFF goes to a RAM of 2^DEPTH_LOG2 words.
//   The RAM is indexed by daddr[DEPTH_LOG2:1], so higher address bits alias.
//   0xFFF0 OUT    read/write output port register
//   0xFFF2 IN     read the synchronized in_port (writes ignored)
//   0xFFF4 TIMER  free-running counter, writable
//   0xFFF6 EVENT  {count[7:0], 7'b0, flag}; any write clears it
//   0xFFF8-0xFFFE read 0, writes ignored
//
// Optional feature macro: DMEM_IO_TIMER_EN
//   Defined: the TIMER counter is built.
//   Undefined: no counter logic; 0xFFF4 reads 0 and ignores writes.
//
// Ports:
//   clock      system clock, rising-edge
//   reset      asynchronous active-low reset
//   daddr      byte address (bit 0 ignored)
//   dwrite     write enable, committed on the next rising edge
//   dread      read enable; ddata is 0 while low
//   dwdata     write data
//   ddata      combinational read data (pre-edge value)
//   in_port    asynchronous external input word
//   in_strobe  asynchronous external event line
//   out_port   registered output port
module dmem_io #(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] daddr,
  input  logic        dwrite,
  input  logic        dread,
  input  logic [15:0] dwdata,
  output logic [15:0] ddata,
  input  logic [15:0] in_port,
  input  logic        in_strobe,
  output logic [15:0] out_port
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_IN    = 3'd1;
  localparam logic [2:0] REG_TIMER = 3'd2;
  localparam logic [2:0] REG_EVENT = 3'd3;

  logic [15:0] mem [WORDS];

  logic                  io_sel;
  logic [2:0]            io_reg;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  wr_ram;
  logic                  wr_out;
  logic                  wr_event;

  logic [15:0] in_meta;
  logic [15:0] in_sync;
  logic        strobe_meta;
  logic        strobe_sync;
  logic        strobe_prev;
  logic        strobe_rise;

  logic        event_flag;
  logic [7:0]  event_count;
  logic [15:0] timer_rd;

  // Byte-lane select bit is meaningless for word-only accesses.
  logic unused_byte_bit;
  assign unused_byte_bit = daddr[0];

  assign io_sel   = (daddr[15:4] == 12'hFFF);
  assign io_reg   = daddr[3:1];
  assign ram_idx  = daddr[DEPTH_LOG2:1];

  assign wr_ram   = dwrite && !io_sel;
  assign wr_out   = dwrite && io_sel && (io_reg == REG_OUT);
  assign wr_event = dwrite && io_sel && (io_reg == REG_EVENT);

  // RAM contents survive reset, but a write landing on an edge while reset
  // is held is dropped. The empty reset action keeps the array un-reset.
  always_ff @(posedge clock or negedge reset) begin
    if (reset && wr_ram) begin
      mem[ram_idx] <= dwdata;
    end
  end

  // Two-flop synchronizers for the asynchronous inputs; strobe_prev is the
  // third flop that turns the synchronized strobe into a one-cycle rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_meta     <= '0;
      in_sync     <= '0;
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_prev <= 1'b0;
    end else begin
      in_meta     <= in_port;
      in_sync     <= in_meta;
      strobe_meta <= in_strobe;
      strobe_sync <= strobe_meta;
      strobe_prev <= strobe_sync;
    end
  end

  assign strobe_rise = strobe_sync && !strobe_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_port <= '0;
    end else if (wr_out) begin
      out_port <= dwdata;
    end
  end

  // A rise arriving together with a clear wins: the clear is absorbed and
  // the rise is counted from zero, leaving flag = 1 and count = 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      event_flag  <= 1'b0;
      event_count <= '0;
    end else if (strobe_rise) begin
      event_flag <= 1'b1;
      if (wr_event) begin
        event_count <= 8'd1;
      end else if (event_count != 8'hFF) begin
        event_count <= event_count + 8'd1;
      end
    end else if (wr_event) begin
      event_flag  <= 1'b0;
      event_count <= '0;
    end
  end

`ifdef DMEM_IO_TIMER_EN
  logic        wr_timer;
  logic [15:0] timer;

  assign wr_timer = dwrite && io_sel && (io_reg == REG_TIMER);

  // A load replaces that cycle's increment; counting resumes from the
  // loaded value on the following edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (wr_timer) begin
      timer <= dwdata;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  assign timer_rd = timer;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    ddata = '0;
    if (dread) begin
      if (io_sel) begin
        case (io_reg)
          REG_OUT:   ddata = out_port;
          REG_IN:    ddata = in_sync;
          REG_TIMER: ddata = timer_rd;
          REG_EVENT: ddata = {event_count, 7'b0, event_flag};
          default:   ddata = '0;
        endcase
      end else begin
        ddata = mem[ram_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_io.sv
// tb_dmem_io: self-checking bench for dmem_io. A behavioural model tracks
// RAM words, I/O registers and input latency with arrays and queues; the
// directed scenarios and a randomized phase are compared against it.
// Honours DMEM_IO_TIMER_EN the same way the design does.
module tb_dmem_io;

  localparam int DEPTH_LOG2 = 7;
  localparam int WORDS      = 1 << DEPTH_LOG2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] daddr = '0;
  logic        dwrite = 1'b0;
  logic        dread = 1'b0;
  logic [15:0] dwdata = '0;
  logic [15:0] ddata;
  logic [15:0] in_port = '0;
  logic        in_strobe = 1'b0;
  logic [15:0] out_port;

  always #5 clock = ~clock;

  dmem_io #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock     (clock),
    .reset     (reset),
    .daddr     (daddr),
    .dwrite    (dwrite),
    .dread     (dread),
    .dwdata    (dwdata),
    .ddata     (ddata),
    .in_port   (in_port),
    .in_strobe (in_strobe),
    .out_port  (out_port)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [15:0] m_ram [WORDS];
  logic [15:0] m_out;
  logic [15:0] m_timer;
  logic        m_flag;
  int          m_count;
  logic [15:0] in_pipe [$];
  logic        strobe_hist [$];

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_out       = '0;
    m_timer     = '0;
    m_flag      = 1'b0;
    m_count     = 0;
    in_pipe     = '{16'h0000, 16'h0000};
    strobe_hist = '{1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [15:0] modelRead(input logic [15:0] addr);
    int reg_no;
    if (addr >= 16'hFFF0) begin
      reg_no = (int'(addr) - 'hFFF0) / 2;
      case (reg_no)
        0: return m_out;
        1: return in_pipe[0];
`ifdef DMEM_IO_TIMER_EN
        2: return m_timer;
`endif
        3: return 16'(m_count * 256 + int'(m_flag));
        default: return 16'h0000;
      endcase
    end
    return m_ram[(int'(addr) / 2) % WORDS];
  endfunction

  // One rising edge of the model: in_port becomes visible two edges after
  // it is sampled, a strobe rise is acted on three edges after sampling.
  function automatic void modelEdge(input logic [15:0] addr, input logic wr,
                                    input logic [15:0] wdata,
                                    input logic strobe, input logic [15:0] inp);
    logic rise;
    logic timer_loaded;
    int   reg_no;
    rise = strobe_hist[1] && !strobe_hist[0];
    timer_loaded = 1'b0;
    if (wr && addr >= 16'hFFF0) begin
      reg_no = (int'(addr) - 'hFFF0) / 2;
      if (reg_no == 0) m_out = wdata;
`ifdef DMEM_IO_TIMER_EN
      if (reg_no == 2) begin
        m_timer = wdata;
        timer_loaded = 1'b1;
      end
`endif
      if (reg_no == 3) begin
        m_flag  = 1'b0;
        m_count = 0;
      end
    end else if (wr) begin
      m_ram[(int'(addr) / 2) % WORDS] = wdata;
    end
`ifdef DMEM_IO_TIMER_EN
    if (!timer_loaded) m_timer = m_timer + 16'd1;
`endif
    if (rise) begin
      m_flag  = 1'b1;
      m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
    end
    in_pipe.push_back(inp);
    void'(in_pipe.pop_front());
    strobe_hist.push_back(strobe);
    void'(strobe_hist.pop_front());
  endfunction

  // Called at a falling edge: drive one access, check the combinational
  // read and out_port before the rising edge, then step the model.
  task automatic applyStimulus(input logic [15:0] addr, input logic wr,
                               input logic rd, input logic [15:0] wdata,
                               output logic [15:0] seen);
    daddr  = addr;
    dwrite = wr;
    dread  = rd;
    dwdata = wdata;
    #1;
    seen = ddata;
    if (rd) checkOutput("ddata", ddata, modelRead(addr));
    else    checkOutput("ddata_idle", ddata, 16'h0000);
    checkOutput("out_port", out_port, m_out);
    @(posedge clock);
    if (!reset) modelReset();
    else        modelEdge(addr, wr, wdata, in_strobe, in_port);
    @(negedge clock);
    dwrite = 1'b0;
    dread  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    logic [15:0] dummy;
    for (int i = 0; i < n; i++) applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000, dummy);
  endtask

  task automatic readReg(input logic [15:0] addr, output logic [15:0] seen);
    applyStimulus(addr, 1'b0, 1'b1, 16'h0000, seen);
  endtask

  task automatic writeReg(input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] dummy;
    applyStimulus(addr, 1'b1, 1'b0, data, dummy);
  endtask

  logic [15:0] seen;

  initial begin
    modelReset();
    for (int i = 0; i < WORDS; i++) m_ram[i] = '0;

    // Reset state while reset is held
    @(negedge clock);
    checkOutput("rst_out_port", out_port, 16'h0000);
    readReg(16'hFFF0, seen);
    checkOutput("rst_out_reg", seen, 16'h0000);
    readReg(16'hFFF4, seen);
    checkOutput("rst_timer", seen, 16'h0000);
    readReg(16'hFFF6, seen);
    checkOutput("rst_event", seen, 16'h0000);
    reset = 1'b1;

    // Give every RAM word a known value
    for (int i = 0; i < WORDS; i++) writeReg(16'(i * 2), 16'($urandom));

    // Aliasing and read-enable gating
    writeReg(16'h0010, 16'h1234);
    writeReg(16'h0110, 16'hBEEF);
    readReg(16'h0010, seen);
    checkOutput("ram_alias", seen, 16'hBEEF);
    applyStimulus(16'h0010, 1'b0, 1'b0, 16'h0000, seen);
    checkOutput("ddata_no_read", seen, 16'h0000);

    // Read/write collision
    writeReg(16'h0020, 16'h1111);
    applyStimulus(16'h0020, 1'b1, 1'b1, 16'h2222, seen);
    checkOutput("collide_old", seen, 16'h1111);
    readReg(16'h0020, seen);
    checkOutput("collide_new", seen, 16'h2222);

    // Output port
    writeReg(16'hFFF0, 16'h00A5);
    checkOutput("out_port_a5", out_port, 16'h00A5);
    readReg(16'hFFF0, seen);
    checkOutput("out_reg_a5", seen, 16'h00A5);

    // Input port latency and ignored writes
    in_port = 16'h1111;
    idleCycles(3);
    in_port = 16'h5A5A;
    readReg(16'hFFF2, seen);
    checkOutput("in_edge0", seen, 16'h1111);
    readReg(16'hFFF2, seen);
    checkOutput("in_edge1", seen, 16'h1111);
    readReg(16'hFFF2, seen);
    checkOutput("in_edge2", seen, 16'h5A5A);
    writeReg(16'hFFF2, 16'hFFFF);
    readReg(16'hFFF2, seen);
    checkOutput("in_write_ignored", seen, 16'h5A5A);

    // Timer load and wrap
    writeReg(16'hFFF4, 16'hFFFE);
`ifdef DMEM_IO_TIMER_EN
    readReg(16'hFFF4, seen);
    checkOutput("timer_0", seen, 16'hFFFE);
    readReg(16'hFFF4, seen);
    checkOutput("timer_1", seen, 16'hFFFF);
    readReg(16'hFFF4, seen);
    checkOutput("timer_2", seen, 16'h0000);
`else
    for (int i = 0; i < 3; i++) begin
      readReg(16'hFFF4, seen);
      checkOutput("timer_absent", seen, 16'h0000);
    end
`endif

    // Three distinct pulses
    writeReg(16'hFFF6, 16'h0000);
    for (int p = 0; p < 3; p++) begin
      in_strobe = 1'b1;
      idleCycles(2);
      in_strobe = 1'b0;
      idleCycles(2);
    end
    idleCycles(4);
    readReg(16'hFFF6, seen);
    checkOutput("event_3", seen, 16'h0301);

    // Held strobe counts once
    writeReg(16'hFFF6, 16'h1234);
    in_strobe = 1'b1;
    idleCycles(20);
    readReg(16'hFFF6, seen);
    checkOutput("event_held", seen, 16'h0101);
    in_strobe = 1'b0;
    idleCycles(4);

    // Saturation
    writeReg(16'hFFF6, 16'h0000);
    for (int p = 0; p < 300; p++) begin
      in_strobe = 1'b1;
      idleCycles(1);
      in_strobe = 1'b0;
      idleCycles(1);
    end
    idleCycles(4);
    readReg(16'hFFF6, seen);
    checkOutput("event_sat", seen, 16'hFF01);

    // Clear coinciding with a detected rise
    writeReg(16'hFFF6, 16'h0000);
    idleCycles(4);
    in_strobe = 1'b1;
    idleCycles(2);
    writeReg(16'hFFF6, 16'h0000);
    readReg(16'hFFF6, seen);
    checkOutput("event_clear_edge", seen, 16'h0101);
    in_strobe = 1'b0;
    idleCycles(4);

    // Asynchronous reset mid-run; pending RAM write dropped
    writeReg(16'h0040, 16'h4444);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_async_out", out_port, 16'h0000);
    @(negedge clock);
    applyStimulus(16'h0040, 1'b1, 1'b1, 16'hDEAD, seen);
    reset = 1'b1;
    readReg(16'h0040, seen);
    checkOutput("rst_write_dropped", seen, 16'h4444);
    readReg(16'hFFF6, seen);
    checkOutput("rst_event_clear", seen, 16'h0000);

    // Randomized mixed traffic against the model
    for (int i = 0; i < 800; i++) begin
      int          kind;
      logic [15:0] a;
      logic        wr;
      logic        rd;
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        a = 16'($urandom);
        if (a[15:4] == 12'hFFF) a[15] = 1'b0;
      end else begin
        a = 16'hFFF0 + 16'(2 * $urandom_range(0, 7)) + 16'($urandom_range(0, 1));
      end
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) in_port = 16'($urandom);
      in_strobe = ($urandom_range(0, 2) == 0);
      applyStimulus(a, wr, rd, 16'($urandom), seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
